// File: rtl/imem_boot_ctrl.sv
// Boot sequencer: streams a byte-wide program into instruction memory as
// little-endian 32-bit words starting at START_WORD, then releases the core
// from reset and supervises its run until halt or a cycle budget expires.
module imem_boot_ctrl #(
  parameter int unsigned START_WORD = 32,
  parameter int unsigned MAX_WORDS  = 1024,
  parameter int unsigned RESET_HOLD = 4,
  parameter int unsigned RUN_CYCLES = 300,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [CNT_W-1:0] word_count_i,
  input  logic             load_valid_i,
  input  logic [7:0]       load_data_i,
  output logic             load_ready_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [3:0]       mem_be_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic             mem_gnt_i,
  output logic             core_rst_no,
  output logic             fetch_enable_o,
  input  logic             halt_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] words_loaded_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_HOLD,
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_WORDS);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD - 1);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_word_idx;
  logic [1:0]       r_byte_idx;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] r_run_cnt;
  logic             r_load_ready;
  logic             r_mem_req;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             r_core_rst_n;
  logic             r_fetch_en;
  logic             r_busy;
  logic             r_done;
  logic             r_timeout;

  logic [CNT_W-1:0] w_count_clamped;
  logic [CNT_W-1:0] w_next_idx;
  logic [31:0]      w_word_addr;

  // Requests beyond MAX_WORDS are silently clamped; the word address is the
  // byte address of the word currently being assembled.
  assign w_count_clamped = (word_count_i > MAX_CNT) ? MAX_CNT : word_count_i;
  assign w_next_idx      = r_word_idx + CNT_W'(1);
  assign w_word_addr     = (32'(START_WORD) + 32'(r_word_idx)) << 2;

  // Sequencer: every output is a direct register copy so nothing glitches
  // towards the memory or the core pins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_word_idx   <= '0;
      r_byte_idx   <= '0;
      r_hold_cnt   <= '0;
      r_run_cnt    <= '0;
      r_load_ready <= 1'b0;
      r_mem_req    <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_core_rst_n <= 1'b0;
      r_fetch_en   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_TIMEOUT: begin
          if (start_i) begin
            r_count      <= w_count_clamped;
            r_word_idx   <= '0;
            r_byte_idx   <= '0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_core_rst_n <= 1'b0;
            r_fetch_en   <= 1'b0;
            r_busy       <= 1'b1;
            if (w_count_clamped == '0) begin
              r_state    <= S_HOLD;
              r_hold_cnt <= '0;
            end else begin
              r_state      <= S_LOAD;
              r_load_ready <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (r_load_ready && load_valid_i) begin
            r_wdata[{r_byte_idx, 3'b000} +: 8] <= load_data_i;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_load_ready <= 1'b0;
              r_mem_req    <= 1'b1;
              r_addr       <= w_word_addr;
              r_state      <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          if (mem_gnt_i) begin
            r_mem_req  <= 1'b0;
            r_word_idx <= w_next_idx;
            if (w_next_idx == r_count) begin
              r_state    <= S_HOLD;
              r_hold_cnt <= '0;
            end else begin
              r_state      <= S_LOAD;
              r_load_ready <= 1'b1;
            end
          end
        end

        S_HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_state      <= S_RUN;
            r_core_rst_n <= 1'b1;
            r_fetch_en   <= 1'b1;
            r_run_cnt    <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + CNT_W'(1);
          end
        end

        S_RUN: begin
          r_run_cnt <= r_run_cnt + CNT_W'(1);
          if (halt_i) begin
            r_state    <= S_DONE;
            r_fetch_en <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
          end else if (r_run_cnt == RUN_LAST) begin
            r_state    <= S_TIMEOUT;
            r_fetch_en <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_timeout  <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign load_ready_o   = r_load_ready;
  assign mem_req_o      = r_mem_req;
  assign mem_we_o       = r_mem_req;
  assign mem_be_o       = {4{r_mem_req}};
  assign mem_addr_o     = r_addr;
  assign mem_wdata_o    = r_wdata;
  assign core_rst_no    = r_core_rst_n;
  assign fetch_enable_o = r_fetch_en;
  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign timeout_o      = r_timeout;
  assign words_loaded_o = r_word_idx;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl: load, stalled grants, timeout, halt
// priority, zero and clamped counts, and reset in the middle of a word.
module tb_imem_boot_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        start_i = 1'b0;
  logic [15:0] word_count_i = '0;
  logic        load_valid_i = 1'b0;
  logic [7:0]  load_data_i = '0;
  logic        load_ready_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i = 1'b0;
  logic        core_rst_no;
  logic        fetch_enable_o;
  logic        halt_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic        timeout_o;
  logic [15:0] words_loaded_o;

  int nChecks = 0;
  int nPass = 0;

  imem_boot_ctrl dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .word_count_i   (word_count_i),
    .load_valid_i   (load_valid_i),
    .load_data_i    (load_data_i),
    .load_ready_o   (load_ready_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (mem_gnt_i),
    .core_rst_no    (core_rst_no),
    .fetch_enable_o (fetch_enable_o),
    .halt_i         (halt_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .timeout_o      (timeout_o),
    .words_loaded_o (words_loaded_o)
  );

  // 100 MHz free-running clock
  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Pulse start_i for one cycle with the given word count
  task automatic applyStimulus(input logic [15:0] wc);
    start_i = 1'b1;
    word_count_i = wc;
    step();
    start_i = 1'b0;
  endtask

  // Stream one word as four back-to-back little-endian bytes
  task automatic sendWord(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      load_valid_i = 1'b1;
      load_data_i = w[8*k +: 8];
      step();
    end
    load_valid_i = 1'b0;
    load_data_i = '0;
  endtask

  task automatic test_reset();
    logic [91:0] allOut;
    #3 rst_ni = 1'b0;
    #1;
    allOut = {load_ready_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
              core_rst_no, fetch_enable_o, busy_o, done_o, timeout_o, words_loaded_o};
    nChecks++;
    if (allOut !== '0) $display("[TB] FAIL reset_outputs: got %h expected 0", allOut);
    else nPass++;
    step();
    step();
    rst_ni = 1'b1;
    step();
    nChecks++;
    if ({core_rst_no, busy_o, mem_req_o} !== 3'b000)
      $display("[TB] FAIL idle_after_reset: got %b expected 000", {core_rst_no, busy_o, mem_req_o});
    else nPass++;
  endtask

  task automatic test_basic_load();
    applyStimulus(16'd2);
    nChecks++;
    if ({load_ready_o, busy_o, core_rst_no} !== 3'b110)
      $display("[TB] FAIL load_entry: got %b expected 110", {load_ready_o, busy_o, core_rst_no});
    else nPass++;
    sendWord(32'h0000_0513);
    nChecks++;
    if ({mem_req_o, mem_we_o, mem_be_o, load_ready_o, mem_addr_o, mem_wdata_o} !==
        {1'b1, 1'b1, 4'hF, 1'b0, 32'h80, 32'h0000_0513})
      $display("[TB] FAIL write0: got req=%b we=%b be=%h rdy=%b addr=%h data=%h expected 1 1 f 0 00000080 00000513",
               mem_req_o, mem_we_o, mem_be_o, load_ready_o, mem_addr_o, mem_wdata_o);
    else nPass++;
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    nChecks++;
    if ({mem_req_o, load_ready_o, words_loaded_o} !== {1'b0, 1'b1, 16'd1})
      $display("[TB] FAIL after_grant0: got req=%b rdy=%b words=%0d expected 0 1 1",
               mem_req_o, load_ready_o, words_loaded_o);
    else nPass++;
    sendWord(32'h0010_0593);
    nChecks++;
    if ({mem_req_o, mem_be_o, mem_addr_o, mem_wdata_o} !== {1'b1, 4'hF, 32'h84, 32'h0010_0593})
      $display("[TB] FAIL write1: got req=%b be=%h addr=%h data=%h expected 1 f 00000084 00100593",
               mem_req_o, mem_be_o, mem_addr_o, mem_wdata_o);
    else nPass++;
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    nChecks++;
    if ({mem_req_o, load_ready_o, core_rst_no, words_loaded_o} !== {1'b0, 1'b0, 1'b0, 16'd2})
      $display("[TB] FAIL hold_entry: got req=%b rdy=%b rstn=%b words=%0d expected 0 0 0 2",
               mem_req_o, load_ready_o, core_rst_no, words_loaded_o);
    else nPass++;
    repeat (3) step();
    nChecks++;
    if ({core_rst_no, fetch_enable_o} !== 2'b00)
      $display("[TB] FAIL hold_last: got %b expected 00", {core_rst_no, fetch_enable_o});
    else nPass++;
    step();
    nChecks++;
    if ({core_rst_no, fetch_enable_o} !== 2'b11)
      $display("[TB] FAIL release: got %b expected 11", {core_rst_no, fetch_enable_o});
    else nPass++;
    halt_i = 1'b1;
    step();
    halt_i = 1'b0;
    nChecks++;
    if ({fetch_enable_o, core_rst_no, done_o, timeout_o, busy_o} !== 5'b01100)
      $display("[TB] FAIL halt_done: got %b expected 01100",
               {fetch_enable_o, core_rst_no, done_o, timeout_o, busy_o});
    else nPass++;
  endtask

  task automatic test_grant_stall();
    applyStimulus(16'd1);
    nChecks++;
    if ({done_o, core_rst_no, load_ready_o} !== 3'b001)
      $display("[TB] FAIL restart_from_done: got %b expected 001", {done_o, core_rst_no, load_ready_o});
    else nPass++;
    sendWord(32'hDEAD_BEEF);
    load_valid_i = 1'b1;
    load_data_i = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      nChecks++;
      if ({mem_req_o, load_ready_o, mem_addr_o, mem_wdata_o} !== {1'b1, 1'b0, 32'h80, 32'hDEAD_BEEF})
        $display("[TB] FAIL stall_cycle%0d: got req=%b rdy=%b addr=%h data=%h expected 1 0 00000080 deadbeef",
                 i, mem_req_o, load_ready_o, mem_addr_o, mem_wdata_o);
      else nPass++;
      mem_gnt_i = (i == 3);
      step();
    end
    mem_gnt_i = 1'b0;
    nChecks++;
    if ({mem_req_o, load_ready_o, words_loaded_o, mem_wdata_o} !== {1'b0, 1'b0, 16'd1, 32'hDEAD_BEEF})
      $display("[TB] FAIL stall_grant: got req=%b rdy=%b words=%0d data=%h expected 0 0 1 deadbeef",
               mem_req_o, load_ready_o, words_loaded_o, mem_wdata_o);
    else nPass++;
    load_valid_i = 1'b0;
    load_data_i = '0;
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 16 && fetch_enable_o !== 1'b1; i++) step();
    nChecks++;
    if (fetch_enable_o !== 1'b1) $display("[TB] FAIL run_entry: got fetch=%b expected 1", fetch_enable_o);
    else nPass++;
    repeat (299) step();
    nChecks++;
    if ({fetch_enable_o, timeout_o, done_o} !== 3'b100)
      $display("[TB] FAIL run_last_cycle: got %b expected 100", {fetch_enable_o, timeout_o, done_o});
    else nPass++;
    step();
    nChecks++;
    if ({fetch_enable_o, core_rst_no, done_o, timeout_o, busy_o} !== 5'b01110)
      $display("[TB] FAIL timeout_state: got %b expected 01110",
               {fetch_enable_o, core_rst_no, done_o, timeout_o, busy_o});
    else nPass++;
  endtask

  task automatic test_zero_count_and_halt_at_expiry();
    int sawReq = 0;
    applyStimulus(16'd0);
    nChecks++;
    if ({busy_o, load_ready_o, mem_req_o, core_rst_no, done_o, timeout_o} !== 6'b100000)
      $display("[TB] FAIL zero_hold_entry: got %b expected 100000",
               {busy_o, load_ready_o, mem_req_o, core_rst_no, done_o, timeout_o});
    else nPass++;
    for (int i = 0; i < 3; i++) begin
      step();
      if (mem_req_o !== 1'b0 || core_rst_no !== 1'b0) sawReq++;
    end
    nChecks++;
    if (sawReq !== 0) $display("[TB] FAIL zero_hold_cycles: got %0d bad cycles expected 0", sawReq);
    else nPass++;
    step();
    nChecks++;
    if ({core_rst_no, fetch_enable_o} !== 2'b11)
      $display("[TB] FAIL zero_release: got %b expected 11", {core_rst_no, fetch_enable_o});
    else nPass++;
    applyStimulus(16'd5);
    nChecks++;
    if ({fetch_enable_o, busy_o, load_ready_o} !== 3'b110)
      $display("[TB] FAIL start_ignored_in_run: got %b expected 110", {fetch_enable_o, busy_o, load_ready_o});
    else nPass++;
    repeat (298) step();
    nChecks++;
    if ({fetch_enable_o, timeout_o} !== 2'b10)
      $display("[TB] FAIL pre_expiry: got %b expected 10", {fetch_enable_o, timeout_o});
    else nPass++;
    halt_i = 1'b1;
    step();
    halt_i = 1'b0;
    nChecks++;
    if ({done_o, timeout_o, fetch_enable_o, core_rst_no} !== 4'b1001)
      $display("[TB] FAIL halt_wins: got %b expected 1001", {done_o, timeout_o, fetch_enable_o, core_rst_no});
    else nPass++;
  endtask

  task automatic test_clamp();
    int badAddr = 0;
    logic [31:0] lastAddr = '0;
    applyStimulus(16'd5000);
    for (int w = 0; w < 1024; w++) begin
      sendWord(32'h1000_0000 + 32'(w));
      if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h80 + 32'(4 * w)) badAddr++;
      lastAddr = mem_addr_o;
      mem_gnt_i = 1'b1;
      step();
      mem_gnt_i = 1'b0;
    end
    nChecks++;
    if (badAddr !== 0) $display("[TB] FAIL clamp_addr_seq: got %0d bad words expected 0", badAddr);
    else nPass++;
    nChecks++;
    if (lastAddr !== 32'h107C) $display("[TB] FAIL clamp_last_addr: got %h expected 0000107c", lastAddr);
    else nPass++;
    nChecks++;
    if ({words_loaded_o, load_ready_o, mem_req_o} !== {16'd1024, 1'b0, 1'b0})
      $display("[TB] FAIL clamp_count: got words=%0d rdy=%b req=%b expected 1024 0 0",
               words_loaded_o, load_ready_o, mem_req_o);
    else nPass++;
    for (int i = 0; i < 16 && fetch_enable_o !== 1'b1; i++) step();
    halt_i = 1'b1;
    step();
    halt_i = 1'b0;
    nChecks++;
    if ({done_o, timeout_o} !== 2'b10)
      $display("[TB] FAIL clamp_finish: got %b expected 10", {done_o, timeout_o});
    else nPass++;
  endtask

  task automatic test_reset_midload();
    logic [91:0] allOut;
    applyStimulus(16'd3);
    load_valid_i = 1'b1;
    load_data_i = 8'h11;
    step();
    load_data_i = 8'h22;
    step();
    load_valid_i = 1'b0;
    load_data_i = '0;
    rst_ni = 1'b0;
    #1;
    allOut = {load_ready_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
              core_rst_no, fetch_enable_o, busy_o, done_o, timeout_o, words_loaded_o};
    nChecks++;
    if (allOut !== '0) $display("[TB] FAIL midload_reset: got %h expected 0", allOut);
    else nPass++;
    step();
    rst_ni = 1'b1;
    step();
    applyStimulus(16'd1);
    nChecks++;
    if (load_ready_o !== 1'b1) $display("[TB] FAIL reload_ready: got %b expected 1", load_ready_o);
    else nPass++;
    sendWord(32'h6655_4433);
    nChecks++;
    if ({mem_req_o, mem_addr_o, mem_wdata_o} !== {1'b1, 32'h80, 32'h6655_4433})
      $display("[TB] FAIL reload_write: got req=%b addr=%h data=%h expected 1 00000080 66554433",
               mem_req_o, mem_addr_o, mem_wdata_o);
    else nPass++;
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    nChecks++;
    if ({words_loaded_o, mem_req_o, load_ready_o} !== {16'd1, 1'b0, 1'b0})
      $display("[TB] FAIL reload_done: got words=%0d req=%b rdy=%b expected 1 0 0",
               words_loaded_o, mem_req_o, load_ready_o);
    else nPass++;
  endtask

  // Scenario sequence; each scenario leaves the DUT where the next expects it
  initial begin
    test_reset();
    test_basic_load();
    test_grant_stall();
    test_timeout();
    test_zero_count_and_halt_at_expiry();
    test_clamp();
    test_reset_midload();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
